// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the arithmetic unit datapaths.
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_subtractor.sv
// N-bit ripple subtractor a - b: two's complement add with b inverted and carry-in 1.
module ripple_subtractor #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_bit
        FullAdder u_fa (
            .a    (a[i]),
            .b    (~b[i]),
            .cin  (carry[i]),
            .sum  (diff[i]),
            .cout (carry[i+1])
        );
    end

    // Carry out of the top bit set means a >= b.
    assign no_borrow = carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// behind a start/ready/done handshake.
module seq_restoring_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    div_state_t state, state_nxt;

    logic [WIDTH-1:0] q;
    logic [RW-1:0]    r;
    logic [RW-1:0]    d;
    logic [CW-1:0]    cnt;

    logic [RW-1:0]    r_shift_c;
    logic [RW-1:0]    diff_c;
    logic             no_borrow_c;
    logic [WIDTH-1:0] q_nxt_c;
    logic [RW-1:0]    r_nxt_c;
    logic             last_c;
    logic             unused_r_msb;

    // Partial remainder never exceeds the divisor, so its top bit is shifted out unused.
    assign unused_r_msb = r[WIDTH];

    assign r_shift_c = {r[WIDTH-1:0], q[WIDTH-1]};
    assign q_nxt_c   = {q[WIDTH-2:0], no_borrow_c};
    assign r_nxt_c   = no_borrow_c ? diff_c : r_shift_c;
    assign last_c    = (cnt == CW'(WIDTH - 1));

    ripple_subtractor #(
        .N (RW)
    ) u_sub (
        .a         (r_shift_c),
        .b         (d),
        .diff      (diff_c),
        .no_borrow (no_borrow_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q           <= '0;
            r           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            ready       <= 1'b1;
            done        <= 1'b0;
        end else begin
            ready <= (state_nxt == IDLE);
            done  <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            q   <= dividend;
                            r   <= '0;
                            d   <= RW'(divisor);
                            cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    q   <= q_nxt_c;
                    r   <= r_nxt_c;
                    cnt <= cnt + CW'(1);
                    if (last_c) begin
                        quotient    <= q_nxt_c;
                        remainder   <= r_nxt_c[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Drive one start for a cycle; returns at the negedge of cycle 1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    // Advance negedge by negedge until done or budget; lat is the cycle index reached.
    task automatic wait_done(input int first, input int budget, output int lat);
        lat = first;
        while (!done && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%b done=%b q=%0d r=%0d dz=%b, required 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_divide(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er,
                               input logic edz, input int elat);
        int lat;
        issue(a, b);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready %0d/%0d: ready=%b, required 0", a, b, ready);
        end
        wait_done(1, 20, lat);
        checks++;
        if (done !== 1'b1 || lat != elat) begin
            errors++;
            $display("FAIL latency %0d/%0d: done=%b at cycle %0d, required done=1 at cycle %0d", a, b, done, lat, elat);
        end
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
            errors++;
            $display("FAIL result %0d/%0d: q=%0d r=%0d dz=%b, required q=%0d r=%0d dz=%b",
                     a, b, quotient, remainder, div_by_zero, eq, er, edz);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || quotient !== eq || remainder !== er) begin
            errors++;
            $display("FAIL after_done %0d/%0d: done=%b ready=%b q=%0d r=%0d, required 0 1 %0d %0d",
                     a, b, done, ready, quotient, remainder, eq, er);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] va [6] = '{4'd13, 4'd15, 4'd3, 4'd0, 4'd15, 4'd8};
        logic [W-1:0] vb [6] = '{4'd4,  4'd1,  4'd7, 4'd5, 4'd15, 4'd3};
        logic [W-1:0] vq [6] = '{4'd3,  4'd15, 4'd0, 4'd0, 4'd1,  4'd2};
        logic [W-1:0] vr [6] = '{4'd1,  4'd0,  4'd3, 4'd0, 4'd0,  4'd2};
        for (int i = 0; i < 6; i++) begin
            test_divide(va[i], vb[i], vq[i], vr[i], 1'b0, 5);
        end
    endtask

    task automatic test_div_by_zero();
        test_divide(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, 1);
    endtask

    task automatic test_ignored_start();
        int lat;
        int seen;
        issue(4'd14, 4'd3);
        checks++;
        if (quotient !== 4'd15 || remainder !== 4'd9 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL held_outputs: q=%0d r=%0d dz=%b, required 15 9 1", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        dividend = 4'd1;
        divisor  = 4'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(3, 20, lat);
        checks++;
        if (done !== 1'b1 || lat != 5 || quotient !== 4'd4 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: done=%b cycle=%0d q=%0d r=%0d dz=%b, required 1 5 4 2 0",
                     done, lat, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ignored_ready: ready=%b, required 1", ready);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || quotient !== 4'd4 || remainder !== 4'd2) begin
            errors++;
            $display("FAIL no_queue: done pulses=%0d q=%0d r=%0d, required 0 4 2", seen, quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(4'd12, 4'd5);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: ready=%b done=%b q=%0d r=%0d dz=%b, required 1 0 0 0 0",
                     ready, done, quotient, remainder, div_by_zero);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_done: done pulses=%0d ready=%b, required 0 1", seen, ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        issue(4'd10, 4'd3);
        wait_done(1, 20, lat1);
        checks++;
        if (done !== 1'b1 || lat1 != 5 || quotient !== 4'd3 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL b2b_first: done=%b cycle=%0d q=%0d r=%0d, required 1 5 3 1", done, lat1, quotient, remainder);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b, required 1", ready);
        end
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: ready=%b, required 0", ready);
        end
        wait_done(lat1 + 2, 40, lat2);
        checks++;
        if (done !== 1'b1 || lat2 - lat1 != 6 || quotient !== 4'd3 || remainder !== 4'd1) begin
            errors++;
            $display("FAIL b2b_second: done=%b spacing=%0d q=%0d r=%0d, required 1 6 3 1",
                     done, lat2 - lat1, quotient, remainder);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
